serial_selftest: RTL and testbench
==================================

Name: serial_selftest

Overview:
Self-contained, parametrised serial loopback self-test engine for the Fomu build. It transmits a configurable burst of 8N1 bytes on o_tx and receives them back on i_rx. Each echoed byte is compared against the expected pattern, and pass/fail plus an error count are reported. It replaces ad-hoc bench-level loopback checking with a synthesizable block that can run on-chip next to the cpu.

Parameters:
CLK_FREQ, 48_000_000, clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate; DIV = CLK_FREQ/BAUD_RATE clocks per bit (DIV >= 4)
N_BYTES, 16, bytes per burst (1..256)
SEED, 8'h01, first pattern byte (LFSR mode: must be non-zero)
TIMEOUT_BITS, 20, bit periods to wait for each echo before counting a loss

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_run  input  1  level; rising edge (0->1 sampled) starts a burst when idle
i_mode  input  1  0 = incrementing pattern, 1 = 8-bit LFSR (x^8+x^6+x^5+x^4+1, Galois); sampled at start
i_rx  input  1  serial receive, idle high, asynchronous (2-flop synchronised internally)
o_tx  output  1  serial transmit, idle high
o_running  output  1  burst in progress
o_done  output  1  burst finished; held until next start or reset
o_status  output  1  1 = last burst had zero errors; valid when o_done=1
o_err_cnt  output  8  mismatches + framing errors + timeouts in last burst, saturating at 255

Behaviour:
- Reset (synchronous, i_rst=1 at posedge): o_tx=1, o_running=0, o_done=0, o_status=0, o_err_cnt=0, FSM=IDLE, both bit engines idle. Reset mid-frame aborts immediately; o_tx returns high the next cycle.
- FSM states: IDLE, SEND, WAIT_ECHO, CHECK, DONE.
- IDLE/DONE: on i_run rising edge: latch mode, pattern <= SEED, byte index <= 0, o_err_cnt <= 0, o_done <= 0, o_running <= 1, go SEND.
- SEND: load pattern into TX engine; go WAIT_ECHO the cycle after TX starts.
- TX frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly DIV clocks, so a frame is 10*DIV clocks. o_tx changes only on bit boundaries.
- RX engine:
  - Arms on a synchronised falling edge of i_rx.
  - Re-samples at DIV/2; if high there, it was a false start and the engine returns to idle.
  - Then samples each data bit every DIV clocks, then the stop bit.
  - Asserts a 1-cycle valid pulse with byte and frame_err (stop bit = 0).
- WAIT_ECHO: the timeout counter counts TIMEOUT_BITS*DIV clocks from TX start.
  - RX valid -> CHECK.
  - Timeout -> error+1 and advance, without checking.
  - RX valid and timeout on the same cycle: valid wins.
- CHECK (1 cycle): error+1 if byte != pattern or frame_err.
  - Advance: pattern <= pattern+1 (mod 256) or LFSR step; index+1.
  - If index == N_BYTES-1 -> DONE, else -> SEND.
- DONE: o_running=0, o_done=1, o_status = (err==0).
- The error counter saturates at 255 and never wraps.
- i_run held high does not retrigger; it must drop and rise again. A rising edge while running is ignored.
- The RX engine stays armed in every state. Stray bytes received outside WAIT_ECHO are discarded.
- Latency: tx start to CHECK with ideal loopback = 10*DIV - DIV/2 + 3 clocks (sync + detect) ± 1.

Decomposition:
- Shared package/include (serial_pkg.vh): FSM state encodings, frame constants (DATA_BITS=8, STOP_BITS=1), LFSR tap mask 8'hB8, and a DIV computation macro.
- Sub-modules serial_tx and serial_rx (one bit engine each, parametrised by DIV), instantiated by serial_selftest. The FSM, pattern generator and counters stay in the top level.

Test Plan:
- Loopback (i_rx=o_tx), DIV=4, N_BYTES=4, mode 0, SEED=8'h01 -> frames 01,02,03,04 on o_tx; o_done=1, o_status=1, o_err_cnt=0.
- Loopback, mode 1, SEED=8'h01, N_BYTES=3 -> TX bytes 01, B8, 5C; o_status=1.
- i_rx tied high, N_BYTES=5 -> each byte times out after 20*DIV clocks; o_err_cnt=5, o_status=0.
- Loopback with bit 0 inverted on RX path, N_BYTES=4 -> o_err_cnt=4; stop bit forced low on byte 2 only -> o_err_cnt=1.
- i_rst pulsed mid-frame of byte 2 -> next cycle o_tx=1, o_running=0, o_err_cnt=0; a new i_run edge restarts from SEED.
- i_run held high for the whole burst plus 100 clocks -> exactly one burst runs. A 1-DIV/4-wide low glitch on idle i_rx -> no byte, no error.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial loopback self-test: FSM encodings,
// frame constants and the pattern/counter helpers.
package serial_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ECHO,
      S_CHECK,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   function automatic int calc_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Galois form of x^8+x^6+x^5+x^4+1, shifting right
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
   endfunction

   function automatic logic [7:0] next_pattern(input logic [7:0] v, input logic lfsr_mode);
      return lfsr_mode ? lfsr_step(v) : v + 8'd1;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/serial_rx.sv
// 8N1 receive bit engine on a pre-synchronised line; rejects false starts
// and flags a low stop bit as a framing error.
module serial_rx
   import serial_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 valid,
   output logic [DATA_BITS-1:0] data,
   output logic                 frame_err
);

   localparam int CNT_W = $clog2(DIV);

   rx_state_t            st;
   logic                 rx_prev;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] sh;

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= RX_IDLE;
         rx_prev   <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         sh        <= '0;
         valid     <= 1'b0;
         data      <= '0;
         frame_err <= 1'b0;
      end else begin
         rx_prev <= rx;
         valid   <= 1'b0;
         case (st)
            RX_IDLE: begin
               if (rx_prev && !rx) begin
                  st  <= RX_START;
                  cnt <= CNT_W'(DIV / 2 - 1);
               end
            end
            RX_START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rx) begin
                  st <= RX_IDLE;
               end else begin
                  st      <= RX_DATA;
                  cnt     <= CNT_W'(DIV - 1);
                  bit_idx <= '0;
               end
            end
            RX_DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  sh      <= {rx, sh[DATA_BITS-1:1]};
                  cnt     <= CNT_W'(DIV - 1);
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1))
                     st <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  valid     <= 1'b1;
                  data      <= sh;
                  frame_err <= !rx;
                  st        <= RX_IDLE;
               end
            end
            default: st <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/serial_tx.sv
// 8N1 transmit bit engine; one frame per start pulse, DIV clocks per bit.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy
);

   localparam int CNT_W = $clog2(DIV);
   localparam int NSH   = DATA_BITS + STOP_BITS;

   logic [CNT_W-1:0] cnt;
   logic [NSH-1:0]   sh;
   logic [3:0]       left;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx   <= 1'b1;
         busy <= 1'b0;
         cnt  <= '0;
         sh   <= '1;
         left <= '0;
      end else if (!busy) begin
         if (start) begin
            tx   <= 1'b0;
            busy <= 1'b1;
            sh   <= {{STOP_BITS{1'b1}}, data};
            cnt  <= CNT_W'(DIV - 1);
            left <= 4'(NSH);
         end
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end else if (left == 4'd0) begin
         busy <= 1'b0;
         tx   <= 1'b1;
      end else begin
         // data bits then stop bit(s), shifting ones in behind
         tx   <= sh[0];
         sh   <= {1'b1, sh[NSH-1:1]};
         left <= left - 4'd1;
         cnt  <= CNT_W'(DIV - 1);
      end
   end

endmodule

// File: rtl/serial_selftest.sv
// Serial loopback self-test: sends a burst of pattern bytes, checks each echo,
// and reports pass/fail with a saturating error count.
//
//   state       | meaning
//   S_IDLE      | waiting for a rising edge on i_run
//   S_SEND      | hand the current pattern byte to the TX engine once it is free
//   S_WAIT_ECHO | waiting for the echoed byte or the per-byte timeout
//   S_CHECK     | compare the received byte, then advance or finish
//   S_DONE      | burst finished, results held; i_run edge restarts
module serial_selftest
   import serial_pkg::*;
#(
   parameter int         CLK_FREQ     = 48_000_000,
   parameter int         BAUD_RATE    = 115_200,
   parameter int         N_BYTES      = 16,
   parameter logic [7:0] SEED         = 8'h01,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_run,
   input  logic       i_mode,
   input  logic       i_rx,
   output logic       o_tx,
   output logic       o_running,
   output logic       o_done,
   output logic       o_status,
   output logic [7:0] o_err_cnt
);

   localparam int         DIV      = calc_div(CLK_FREQ, BAUD_RATE);
   localparam int         TMO_LOAD = TIMEOUT_BITS * DIV;
   localparam int         TMO_W    = $clog2(TMO_LOAD + 1);
   localparam logic [7:0] LAST_IDX = 8'(N_BYTES - 1);

   state_t           state;
   logic             mode_q;
   logic             run_prev;
   logic [7:0]       pattern;
   logic [7:0]       idx;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]       rx_byte_q;
   logic             rx_ferr_q;
   logic [1:0]       rx_sync;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_busy;
   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             rx_ferr;
   logic             finish_byte;
   logic             byte_bad;

   serial_tx #(.DIV(DIV)) u_tx (
      .clk   (i_clk),
      .rst   (i_rst),
      .start (tx_start),
      .data  (tx_data),
      .tx    (o_tx),
      .busy  (tx_busy)
   );

   serial_rx #(.DIV(DIV)) u_rx (
      .clk       (i_clk),
      .rst       (i_rst),
      .rx        (rx_sync[1]),
      .valid     (rx_valid),
      .data      (rx_data),
      .frame_err (rx_ferr)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)
         rx_sync <= 2'b11;
      else
         rx_sync <= {rx_sync[0], i_rx};
   end

   // A byte is closed either by its check or by a timeout with no echo that cycle
   always_comb begin
      finish_byte = 1'b0;
      byte_bad    = 1'b1;
      if (state == S_CHECK) begin
         finish_byte = 1'b1;
         byte_bad    = (rx_byte_q != pattern) || rx_ferr_q;
      end else if (state == S_WAIT_ECHO && !rx_valid && tmo_cnt == '0) begin
         finish_byte = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         mode_q    <= 1'b0;
         run_prev  <= 1'b1;
         pattern   <= SEED;
         idx       <= '0;
         tmo_cnt   <= '0;
         rx_byte_q <= '0;
         rx_ferr_q <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         o_running <= 1'b0;
         o_done    <= 1'b0;
         o_status  <= 1'b0;
         o_err_cnt <= '0;
      end else begin
         run_prev <= i_run;
         tx_start <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (i_run && !run_prev) begin
                  mode_q    <= i_mode;
                  pattern   <= SEED;
                  idx       <= '0;
                  o_err_cnt <= '0;
                  o_done    <= 1'b0;
                  o_status  <= 1'b0;
                  o_running <= 1'b1;
                  state     <= S_SEND;
               end
            end
            S_SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= pattern;
                  tmo_cnt  <= TMO_W'(TMO_LOAD);
                  state    <= S_WAIT_ECHO;
               end
            end
            S_WAIT_ECHO: begin
               if (rx_valid) begin
                  rx_byte_q <= rx_data;
                  rx_ferr_q <= rx_ferr;
                  state     <= S_CHECK;
               end else if (tmo_cnt != '0) begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            default: ;
         endcase

         if (finish_byte) begin
            if (byte_bad)
               o_err_cnt <= sat_inc(o_err_cnt);
            pattern <= next_pattern(pattern, mode_q);
            idx     <= idx + 8'd1;
            if (idx == LAST_IDX) begin
               state     <= S_DONE;
               o_running <= 1'b0;
               o_done    <= 1'b1;
               o_status  <= (o_err_cnt == 8'd0) && !byte_bad;
            end else begin
               state <= S_SEND;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_selftest.sv
// Bench for serial_selftest: loopback with fault injection on the RX path,
// TX frames decoded independently and scored against expected pattern bytes.
module tb_serial_selftest;

   localparam int DIV = 4;
   localparam int NB  = 4;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_run = 1'b0;
   logic       i_mode = 1'b0;
   logic       i_rx;
   logic       o_tx;
   logic       o_running;
   logic       o_done;
   logic       o_status;
   logic [7:0] o_err_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   logic rx_high = 1'b0;
   logic inv_bit0 = 1'b0;
   logic kill_en = 1'b0;
   logic glitch = 1'b0;
   int   kill_target = -1;

   bit         mon_busy = 1'b0;
   int         mon_cyc = 0;
   int         mon_cur = 0;
   int         mon_frames = 0;
   logic [7:0] mon_byte = 8'h00;
   logic [7:0] exp_byte;
   logic [7:0] exp_q[$];

   logic [7:0] inc_pat [NB] = '{8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0] lfsr_pat[NB] = '{8'h01, 8'hB8, 8'h5C, 8'h2E};

   logic inv_now;
   logic kill_now;

   assign inv_now  = inv_bit0 && mon_busy && mon_cyc >= DIV && mon_cyc < 2 * DIV;
   assign kill_now = kill_en && mon_busy && mon_cur == kill_target && mon_cyc >= 9 * DIV;
   assign i_rx     = glitch ? 1'b0 : rx_high ? 1'b1 : ((o_tx ^ inv_now) & ~kill_now);

   always #5 clk = ~clk;

   serial_selftest #(
      .CLK_FREQ     (460_800),
      .BAUD_RATE    (115_200),
      .N_BYTES      (NB),
      .SEED         (8'h01),
      .TIMEOUT_BITS (20)
   ) dut (
      .i_clk     (clk),
      .i_rst     (i_rst),
      .i_run     (i_run),
      .i_mode    (i_mode),
      .i_rx      (i_rx),
      .o_tx      (o_tx),
      .o_running (o_running),
      .o_done    (o_done),
      .o_status  (o_status),
      .o_err_cnt (o_err_cnt)
   );

   // TX line decoder: mid-bit sampling, scored against the expected queue
   always @(negedge clk) begin
      if (i_rst) begin
         mon_busy = 1'b0;
      end else if (!mon_busy) begin
         if (o_tx == 1'b0) begin
            mon_busy = 1'b1;
            mon_cyc  = 0;
            mon_cur  = mon_frames;
         end
      end else begin
         mon_cyc++;
         if (mon_cyc >= DIV + DIV / 2 && mon_cyc < 9 * DIV && (mon_cyc % DIV) == DIV / 2) begin
            mon_byte[(mon_cyc - DIV - DIV / 2) / DIV] = o_tx;
         end else if (mon_cyc == 9 * DIV + DIV / 2) begin
            tests_run++;
            mon_frames++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL tx_frame: got byte %02h, no byte expected", mon_byte);
            end else begin
               exp_byte = exp_q.pop_front();
               if (mon_byte !== exp_byte || o_tx !== 1'b1) begin
                  tests_failed++;
                  $display("FAIL tx_frame: got byte %02h stop %b, expected byte %02h stop 1",
                           mon_byte, o_tx, exp_byte);
               end
            end
         end else if (mon_cyc >= 10 * DIV) begin
            mon_busy = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic mode);
      for (int i = 0; i < NB; i++)
         exp_q.push_back(mode ? lfsr_pat[i] : inc_pat[i]);
   endtask

   task automatic start_burst(input logic mode);
      push_exp(mode);
      i_mode = mode;
      i_run  = 1'b1;
      tick();
      i_run  = 1'b0;
   endtask

   task automatic wait_done(output bit ok, output int cycles);
      ok = 1'b0;
      cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         if (o_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
         cycles++;
      end
   endtask

   task automatic check_result(input string name, input logic [7:0] exp_err, input logic exp_status);
      tests_run++;
      if (o_err_cnt !== exp_err) begin
         tests_failed++;
         $display("FAIL %s err_cnt: got %0d expected %0d", name, o_err_cnt, exp_err);
      end
      tests_run++;
      if (o_status !== exp_status || o_running !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s status/running: got %b/%b expected %b/0", name, o_status, o_running, exp_status);
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL %s frames: %0d expected bytes never seen on o_tx", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_and_check(input string name, input logic mode, input logic [7:0] exp_err,
                                input logic exp_status);
      bit ok;
      int cyc;
      start_burst(mode);
      wait_done(ok, cyc);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL %s done: o_done still %b after %0d cycles, expected 1", name, o_done, cyc);
      end
      check_result(name, exp_err, exp_status);
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_run = 1'b0;
      repeat (3) tick();
      tests_run++;
      if (o_tx !== 1'b1 || o_running !== 1'b0 || o_done !== 1'b0 || o_status !== 1'b0 || o_err_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset: got tx=%b run=%b done=%b status=%b err=%0d expected 1 0 0 0 0",
                  o_tx, o_running, o_done, o_status, o_err_cnt);
      end
      i_rst = 1'b0;
      repeat (5) tick();
      tests_run++;
      if (o_tx !== 1'b1 || o_running !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: got tx=%b run=%b expected 1 0", o_tx, o_running);
      end
   endtask

   task automatic test_incr();
      run_and_check("incr", 1'b0, 8'd0, 1'b1);
   endtask

   task automatic test_lfsr();
      run_and_check("lfsr", 1'b1, 8'd0, 1'b1);
   endtask

   task automatic test_timeout();
      bit ok;
      int cyc;
      rx_high = 1'b1;
      start_burst(1'b0);
      wait_done(ok, cyc);
      tests_run++;
      if (!ok || cyc < NB * 20 * DIV) begin
         tests_failed++;
         $display("FAIL timeout_len: done=%b after %0d cycles, expected done after at least %0d",
                  o_done, cyc, NB * 20 * DIV);
      end
      check_result("timeout", 8'd4, 1'b0);
      rx_high = 1'b0;
   endtask

   task automatic test_bit0_err();
      inv_bit0 = 1'b1;
      run_and_check("bit0_err", 1'b0, 8'd4, 1'b0);
      inv_bit0 = 1'b0;
   endtask

   task automatic test_stop_err();
      kill_en     = 1'b1;
      kill_target = mon_frames + 1;
      run_and_check("stop_err", 1'b0, 8'd1, 1'b0);
      kill_en     = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int  base;
      bit  hit;
      base = mon_frames;
      inv_bit0 = 1'b1;
      start_burst(1'b0);
      hit = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (mon_busy && mon_cur == base + 1 && mon_cyc >= 2 * DIV) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      tests_run++;
      if (!hit || o_err_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL mid_frame: reached=%b err=%0d, expected reached=1 err=1", hit, o_err_cnt);
      end
      i_rst = 1'b1;
      tick();
      tests_run++;
      if (o_tx !== 1'b1 || o_running !== 1'b0 || o_err_cnt !== 8'd0 || o_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: got tx=%b run=%b err=%0d done=%b expected 1 0 0 0",
                  o_tx, o_running, o_err_cnt, o_done);
      end
      i_rst = 1'b0;
      inv_bit0 = 1'b0;
      exp_q.delete();
      repeat (2) tick();
      run_and_check("restart", 1'b0, 8'd0, 1'b1);
   endtask

   task automatic test_run_held();
      bit ok;
      int cyc;
      int base;
      base = mon_frames;
      push_exp(1'b0);
      i_mode = 1'b0;
      i_run  = 1'b1;
      tick();
      wait_done(ok, cyc);
      repeat (100) tick();
      tests_run++;
      if (!ok || mon_frames - base != NB || o_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL run_held: done=%b frames=%0d expected done=1 frames=%0d",
                  o_done, mon_frames - base, NB);
      end
      check_result("run_held", 8'd0, 1'b1);
      i_run = 1'b0;
      tick();
   endtask

   task automatic test_glitch();
      glitch = 1'b1;
      tick();
      glitch = 1'b0;
      tick();
      run_and_check("glitch", 1'b0, 8'd0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_incr();
      test_lfsr();
      test_timeout();
      test_bit0_err();
      test_stop_err();
      test_reset_midframe();
      test_run_held();
      test_glitch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
      $fatal(1, "watchdog expired");
   end

endmodule
